cp0_ctrl: RTL

Parametrised coprocessor-0 for the pipelined MIPS core. It holds SR, Cause, EPC, PRId and an optional Count/Compare timer. It decides interrupt or exception entry for the instruction in the M stage, captures EPC and BD, and services mfc0, mtc0 and eret. It sits beside the M stage. Its outputs feed the NPC (EPC), the pipeline flush logic (`int_req`) and the GRF write-back mux (`rd_data`).

---
 rtl/cp0_pkg.sv | 40 ++++
 rtl/cp0_timer.sv | 41 ++++
 rtl/cp0_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 block.
//   - CP0 register numbers used by mfc0/mtc0
//   - ExcCode values delivered by the pipeline
//   - SR/Cause bit positions and packing helpers for the read path
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Widest supported interrupt vector; IM/IP live in bits 15:10.
  localparam int MAX_INT      = 6;
  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int IM_LO        = 10;
  localparam int IM_HI        = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_BD_BIT = 31;

  function automatic logic [31:0] pack_sr(input logic [MAX_INT-1:0] im,
                                          input logic exl, input logic ie);
    return {16'b0, im, 8'b0, exl, ie};
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd,
                                             input logic [MAX_INT-1:0] ip,
                                             input logic [4:0] exc);
    return {bd, 15'b0, ip, 3'b0, exc, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer for coprocessor 0.
//   clk, reset      : clock, asynchronous active-high reset
//   count_we        : mtc0 to Count (already gated by entry)
//   compare_we      : mtc0 to Compare (already gated by entry)
//   wr_data         : mtc0 data
//   count, compare  : current register contents for mfc0
//   timer_pend      : sticky timer interrupt, cleared by a Compare write
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pend
);

  logic [31:0] count_nxt;

  // A software write replaces the increment for that edge; the match is
  // taken against whatever Count becomes.
  assign count_nxt = count_we ? wr_data : count + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      compare    <= '0;
      timer_pend <= 1'b0;
    end else begin
      count <= count_nxt;
      if (compare_we) begin
        compare    <= wr_data;
        timer_pend <= 1'b0;
      end else if (count_nxt == compare) begin
        timer_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor 0 for the pipelined MIPS core, sitting beside the
// M stage. Holds SR, Cause, EPC, PRId and (with CP0_TIMER_EN defined) the
// Count/Compare timer. Decides interrupt/exception entry for the M-stage
// instruction and services mfc0, mtc0 and eret.
//   clk, reset     : clock, asynchronous active-high reset
//   rd_addr        : mfc0 register number
//   wr_addr, wr_data, we : mtc0 port
//   pc_m, in_delay_slot, exc_code, eret : M-stage instruction status
//   hw_int[N_INT]  : level-sensitive external interrupt lines
//   int_req        : take the handler this cycle (combinational)
//   epc_out        : current EPC
//   rd_data        : mfc0 read data (combinational, no write bypass)
// Optional feature macro: CP0_TIMER_EN (Count=9, Compare=11, timer on
// interrupt line N_INT-1).
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int          N_INT      = 6,
  parameter logic [31:0] PRID_VALUE = 32'h12345678
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rd_addr,
  input  logic [4:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             we,
  input  logic [31:0]      pc_m,
  input  logic             in_delay_slot,
  input  logic [4:0]       exc_code,
  input  logic             eret,
  input  logic [N_INT-1:0] hw_int,
  output logic             int_req,
  output logic [31:0]      epc_out,
  output logic [31:0]      rd_data
);

  // Implemented IM/IP bits; the rest stay zero.
  localparam logic [MAX_INT-1:0] INT_MASK = {MAX_INT{1'b1}} >> (MAX_INT - N_INT);

  logic [MAX_INT-1:0] im;
  logic [MAX_INT-1:0] ip;
  logic [MAX_INT-1:0] ipv;
  logic               exl;
  logic               ie;
  logic               bd;
  logic [4:0]         exc_field;
  logic [31:0]        epc;
  logic               irq;
  logic               exc;
  logic               wr_ok;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_pend;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr_ok && (wr_addr == REG_COUNT)),
    .compare_we (wr_ok && (wr_addr == REG_COMPARE)),
    .wr_data    (wr_data),
    .count      (count),
    .compare    (compare),
    .timer_pend (timer_pend)
  );
`endif

  // Live pending vector; the timer shares the highest interrupt line.
  always_comb begin
    ipv = '0;
    ipv[N_INT-1:0] = hw_int;
`ifdef CP0_TIMER_EN
    ipv[N_INT-1] = hw_int[N_INT-1] | timer_pend;
`endif
  end

  assign irq     = (|(ipv & im)) & ie & ~exl;
  assign exc     = |exc_code;
  assign int_req = irq | exc;
  assign wr_ok   = we & ~int_req;
  assign epc_out = epc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im        <= '0;
      ip        <= '0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      bd        <= 1'b0;
      exc_field <= '0;
      epc       <= '0;
    end else begin
      ip <= ipv;
      if (int_req) begin
        // Entry beats eret and mtc0 on the same edge.
        exl       <= 1'b1;
        exc_field <= irq ? EXC_INT : exc_code;
        bd        <= in_delay_slot;
        // pc_m is masked rather than sliced so the low bits are dropped
        // explicitly; a delay-slot instruction restarts at its branch.
        epc       <= (pc_m & 32'hFFFF_FFFC) - (in_delay_slot ? 32'd4 : 32'd0);
      end else begin
        if (eret) begin
          exl <= 1'b0;
          bd  <= 1'b0;
        end
        // Placed after eret so an SR write's EXL takes precedence.
        if (we) begin
          case (wr_addr)
            REG_SR: begin
              im  <= wr_data[IM_HI:IM_LO] & INT_MASK;
              exl <= wr_data[SR_EXL_BIT];
              ie  <= wr_data[SR_IE_BIT];
            end
            REG_EPC: epc <= wr_data;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_SR:    rd_data = pack_sr(im, exl, ie);
      REG_CAUSE: rd_data = pack_cause(bd, ip, exc_field);
      REG_EPC:   rd_data = epc;
      REG_PRID:  rd_data = PRID_VALUE;
`ifdef CP0_TIMER_EN
      REG_COUNT:   rd_data = count;
      REG_COMPARE: rd_data = compare;
`endif
      default:   rd_data = '0;
    endcase
  end

endmodule
